// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte requesters.
// A byte is taken over a valid/ready handshake, launched with a one-cycle start pulse,
// and the next grant is held off until the transmitter reports frame done plus an
// idle gap counted in baud ticks.
module uart_tx_arbiter #(
  parameter int unsigned D_W       = 8,
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned GAP_TICKS = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     baud_clk_i,
  input  logic [N_REQ-1:0]         req_valid_i,
  input  logic [N_REQ*D_W-1:0]     req_data_i,
  output logic [N_REQ-1:0]         req_ready_o,
  output logic                     tx_start_o,
  output logic [D_W-1:0]           tx_data_o,
  output logic [$clog2(N_REQ)-1:0] tx_src_o,
  input  logic                     tx_done_i,
  output logic                     busy_o
);

  localparam int unsigned SrcW    = $clog2(N_REQ);
  // Keep the counter at least one bit wide so GAP_TICKS=0 still elaborates.
  localparam int unsigned CntW    = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
  localparam int unsigned GapLast = (GAP_TICKS > 0) ? GAP_TICKS - 1 : 0;

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StWaitDone,
    StGap
  } state_e;

  state_e          state_q, state_d;
  logic [D_W-1:0]  data_q, data_d;
  logic [SrcW-1:0] src_q, src_d;
  logic [SrcW-1:0] last_q, last_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            grant_vld;
  logic [SrcW-1:0] grant_idx;
  logic [SrcW-1:0] scan_idx;
  logic [D_W-1:0]  sel_data;

  // Pick the first valid requester after the last one served, wrapping around.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      scan_idx = SrcW'((32'(last_q) + k) % N_REQ);
      if (!grant_vld && req_valid_i[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  // Byte of the winning requester and the combinational one-hot accept.
  always_comb begin
    sel_data    = D_W'(req_data_i >> (32'(grant_idx) * D_W));
    req_ready_o = (state_q == StIdle && grant_vld) ? (N_REQ'(1) << grant_idx) : '0;
  end

  // Next-state logic: grant, launch, wait for frame done, then idle gap.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    src_d   = src_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (grant_vld) begin
          data_d  = sel_data;
          src_d   = grant_idx;
          last_d  = grant_idx;
          state_d = StLaunch;
        end
      end
      StLaunch: begin
        state_d = StWaitDone;
      end
      StWaitDone: begin
        // A baud tick coinciding with tx_done is not part of the gap.
        if (tx_done_i) begin
          cnt_d   = '0;
          state_d = (GAP_TICKS == 0) ? StIdle : StGap;
        end
      end
      StGap: begin
        if (baud_clk_i) begin
          if (cnt_q == CntW'(GapLast)) begin
            state_d = StIdle;
          end
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and frame registers; last grant resets to N_REQ-1 so requester 0 goes first.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      data_q  <= '0;
      src_q   <= '0;
      last_q  <= SrcW'(N_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      src_q   <= src_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign tx_start_o = (state_q == StLaunch);
  assign tx_data_o  = data_q;
  assign tx_src_o   = src_q;
  assign busy_o     = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a rule-level reference model, a transmitter
// model that answers each start with a delayed done pulse, and a free-running baud tick.
module tb_uart_tx_arbiter;

  localparam int GAP = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        baud;
  logic        tx_done;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [1:0]  tx_src;
  logic        busy;

  // Gap-free instance
  logic [3:0]  v0, r0;
  logic [31:0] d0;
  logic        done0, s0, b0;
  logic [7:0]  td0;
  logic [1:0]  ts0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Transmitter model and stimulus knobs
  bit auto_tx;
  int tx_lat;
  int done_cnt;
  bit force_done;
  int baud_div;
  int n_start, n_done, last_done_idx;
  int l_src[$];
  logic [7:0] l_data[$];

  // Reference model state
  bit         m_free;
  bit         m_start_due;
  bit         m_in_flight;
  int         m_gap_left;
  int         m_last;
  int         m_src;
  logic [7:0] m_data;
  bit         m_hs;

  uart_tx_arbiter #(.D_W(8), .N_REQ(4), .GAP_TICKS(GAP)) dut (
    .clk_i(clk), .rst_i(rst), .baud_clk_i(baud), .req_valid_i(req_valid),
    .req_data_i(req_data), .req_ready_o(req_ready), .tx_start_o(tx_start),
    .tx_data_o(tx_data), .tx_src_o(tx_src), .tx_done_i(tx_done), .busy_o(busy)
  );

  uart_tx_arbiter #(.D_W(8), .N_REQ(4), .GAP_TICKS(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .baud_clk_i(baud), .req_valid_i(v0),
    .req_data_i(d0), .req_ready_o(r0), .tx_start_o(s0),
    .tx_data_o(td0), .tx_src_o(ts0), .tx_done_i(done0), .busy_o(b0)
  );

  initial forever #5 clk = ~clk;

  function automatic int rr(int last, logic [3:0] v);
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (last + k) % 4;
      if (v[2'(i)]) return i;
    end
    return 0;
  endfunction

  function automatic logic [3:0] exp_ready();
    if (!m_free || req_valid == 4'b0) return 4'b0;
    return 4'b0001 << rr(m_last, req_valid);
  endfunction

  // One clock: update the model from the inputs the DUT sees at this edge, take the
  // edge, record launches, then drive the transmitter and baud inputs for the next edge.
  task automatic step();
    m_hs = 1'b0;
    if (rst) begin
      m_free = 1'b1; m_start_due = 1'b0; m_in_flight = 1'b0; m_gap_left = 0;
      m_last = 3; m_src = 0; m_data = 8'h00; done_cnt = 0;
    end else if (m_free && req_valid != 4'b0) begin
      m_src = rr(m_last, req_valid);
      m_last = m_src;
      m_data = 8'(req_data >> (8 * m_src));
      m_free = 1'b0;
      m_start_due = 1'b1;
      m_hs = 1'b1;
    end else if (m_start_due) begin
      m_start_due = 1'b0;
      m_in_flight = 1'b1;
    end else if (m_in_flight) begin
      if (tx_done) begin
        m_in_flight = 1'b0;
        m_gap_left = GAP;
        if (GAP == 0) m_free = 1'b1;
      end
    end else if (m_gap_left > 0 && baud) begin
      m_gap_left--;
      if (m_gap_left == 0) m_free = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (tx_start) begin
      n_start++;
      l_src.push_back(int'(tx_src));
      l_data.push_back(tx_data);
      if (auto_tx) done_cnt = tx_lat;
    end
    #1;
    tx_done = force_done;
    force_done = 1'b0;
    if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) tx_done = 1'b1;
    end
    if (tx_done) begin
      n_done++;
      last_done_idx = cyc;
    end
    baud = (cyc % baud_div) == 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = 4'b0; v0 = 4'b0; done0 = 1'b0;
    auto_tx = 1'b0; force_done = 1'b0;
    step();
    step();
    rst = 1'b0;
    n_start = 0; n_done = 0;
    l_src.delete();
    l_data.delete();
  endtask

  // Run until the model and transmitter are both idle; ok=0 if the bound expires.
  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (m_free && done_cnt == 0 && !m_start_due) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b want=0", busy); end
    checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL reset_start got=%0b want=0", tx_start); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%0h want=00", tx_data); end
    checks++; if (tx_src !== 2'd0) begin failures++; $display("FAIL reset_src got=%0d want=0", tx_src); end
    checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL reset_ready got=%b want=0000", req_ready); end
    checks++; if (b0 !== 1'b0) begin failures++; $display("FAIL reset_busy_nogap got=%0b want=0", b0); end
    req_valid = 4'hF;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL reset_first_prio got=%b want=0001", req_ready); end
    req_valid = 4'h0;
    #1;
  endtask

  task automatic test_single();
    int j, ticks, want_free, got_free;
    bit ok;
    do_reset();
    auto_tx = 1'b1; tx_lat = 40; baud_div = 10;
    req_data = {$urandom_range(0, 255) > 127 ? 24'h123456 : 24'h654321, 8'hA5};
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_ready got=%b want=0001", req_ready); end
    step();
    req_valid = 4'b0;
    checks++; if (tx_start !== 1'b1) begin failures++; $display("FAIL single_start got=%0b want=1", tx_start); end
    checks++; if (tx_data !== 8'hA5) begin failures++; $display("FAIL single_data got=%0h want=a5", tx_data); end
    checks++; if (tx_src !== 2'd0) begin failures++; $display("FAIL single_src got=%0d want=0", tx_src); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%0b want=1", busy); end
    got_free = -1;
    for (int i = 0; i < 2000 && got_free < 0; i++) begin
      step();
      #1;
      checks++; if (busy !== !m_free) begin failures++; $display("FAIL single_busy_trace cyc=%0d got=%0b want=%0b", cyc, busy, !m_free); end
      checks++; if (tx_start !== m_start_due) begin failures++; $display("FAIL single_start_trace cyc=%0d got=%0b want=%0b", cyc, tx_start, m_start_due); end
      if (busy === 1'b0) got_free = cyc;
    end
    // First idle cycle follows the 16th baud tick strictly after the done pulse.
    j = last_done_idx; ticks = 0;
    while (ticks < GAP) begin
      j++;
      if (j % 10 == 0) ticks++;
    end
    want_free = j + 1;
    checks++; if (got_free != want_free) begin failures++; $display("FAIL single_gap_end got=%0d want=%0d", got_free, want_free); end
    checks++; if (tx_data !== 8'hA5 || tx_src !== 2'd0) begin failures++; $display("FAIL single_retain got=%0h/%0d want=a5/0", tx_data, tx_src); end
    drain(ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_drain got=timeout want=idle"); end
  endtask

  task automatic test_round_robin();
    int want_src[5] = '{0, 1, 2, 3, 0};
    logic [7:0] want_data[5] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};
    bit ok;
    do_reset();
    auto_tx = 1'b1; tx_lat = 160; baud_div = 10;
    req_data = 32'h4332_2110;
    req_valid = 4'hF;
    for (int i = 0; i < 6000 && l_src.size() < 5; i++) begin
      step();
      if (l_src.size() >= 5) req_valid = 4'h0;
      #1;
      checks++; if (req_ready !== exp_ready()) begin failures++; $display("FAIL rr_ready cyc=%0d got=%b want=%b", cyc, req_ready, exp_ready()); end
      checks++; if (busy !== !m_free) begin failures++; $display("FAIL rr_busy cyc=%0d got=%0b want=%0b", cyc, busy, !m_free); end
    end
    req_valid = 4'h0;
    drain(ok);
    checks++; if (!ok || l_src.size() != 5) begin failures++; $display("FAIL rr_count got=%0d want=5", l_src.size()); end
    for (int k = 0; k < 5 && k < l_src.size(); k++) begin
      checks++; if (l_src[k] != want_src[k]) begin failures++; $display("FAIL rr_order[%0d] got=%0d want=%0d", k, l_src[k], want_src[k]); end
      checks++; if (l_data[k] !== want_data[k]) begin failures++; $display("FAIL rr_data[%0d] got=%0h want=%0h", k, l_data[k], want_data[k]); end
    end
    checks++; if (n_start != n_done) begin failures++; $display("FAIL rr_start_per_done got=%0d want=%0d", n_start, n_done); end
  endtask

  task automatic test_spurious();
    logic [7:0] b;
    bit idle;
    do_reset();
    auto_tx = 1'b0; baud_div = 10;
    force_done = 1'b1;
    step();
    step();
    #1;
    checks++; if (busy !== 1'b0 || req_ready !== 4'b0) begin failures++; $display("FAIL spur_idle got=%0b/%b want=0/0000", busy, req_ready); end
    b = 8'($urandom);
    req_data = 32'(b) << 16;
    req_valid = 4'b0100;
    step();
    req_valid = 4'b0;
    step();
    req_valid = 4'hF;
    for (int i = 0; i < 20; i++) begin
      step();
      #1;
      checks++; if (req_ready !== 4'b0 || busy !== 1'b1) begin failures++; $display("FAIL spur_wait cyc=%0d got=%b/%0b want=0000/1", cyc, req_ready, busy); end
      checks++; if (tx_data !== b || tx_src !== 2'd2) begin failures++; $display("FAIL spur_hold got=%0h/%0d want=%0h/2", tx_data, tx_src, b); end
    end
    force_done = 1'b1;
    step();
    step();
    force_done = 1'b1;
    idle = 1'b0;
    for (int i = 0; i < 1000 && !idle; i++) begin
      step();
      #1;
      checks++; if (busy !== !m_free) begin failures++; $display("FAIL spur_gap_busy cyc=%0d got=%0b want=%0b", cyc, busy, !m_free); end
      checks++; if (req_ready !== exp_ready()) begin failures++; $display("FAIL spur_gap_ready cyc=%0d got=%b want=%b", cyc, req_ready, exp_ready()); end
      idle = m_free;
    end
    checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL spur_next_grant got=%b want=1000", req_ready); end
    checks++; if (n_start != 1) begin failures++; $display("FAIL spur_starts got=%0d want=1", n_start); end
    req_valid = 4'b0;
    step();
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    auto_tx = 1'b1; tx_lat = 200; baud_div = 10;
    req_data = $urandom;
    req_valid = 4'b0100;
    step();
    for (int i = 0; i < 5; i++) step();
    #1;
    checks++; if (busy !== 1'b1 || req_ready !== 4'b0) begin failures++; $display("FAIL midrst_wait got=%0b/%b want=1/0000", busy, req_ready); end
    rst = 1'b1;
    req_valid = 4'b0101;
    step();
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%0b want=0", busy); end
    checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL midrst_nostart got=%0b want=0", tx_start); end
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL midrst_prio got=%b want=0001", req_ready); end
    step();
    req_valid = 4'b0;
    checks++; if (tx_start !== 1'b1 || tx_src !== 2'd0) begin failures++; $display("FAIL midrst_launch got=%0b/%0d want=1/0", tx_start, tx_src); end
    checks++; if (tx_data !== req_data[7:0]) begin failures++; $display("FAIL midrst_data got=%0h want=%0h", tx_data, req_data[7:0]); end
    checks++; if (n_start != 2) begin failures++; $display("FAIL midrst_starts got=%0d want=2", n_start); end
    drain(ok);
    checks++; if (!ok) begin failures++; $display("FAIL midrst_drain got=timeout want=idle"); end
  endtask

  task automatic test_wrap();
    int want_src[3] = '{3, 3, 1};
    bit ok;
    do_reset();
    auto_tx = 1'b1; tx_lat = 30; baud_div = 10;
    req_data = $urandom;
    req_valid = 4'b1000;
    for (int i = 0; i < 4000 && l_src.size() < 3; i++) begin
      step();
      if (l_src.size() == 2) req_valid = 4'b1010;
      if (l_src.size() >= 3) req_valid = 4'b0;
      #1;
      checks++; if (req_ready !== exp_ready()) begin failures++; $display("FAIL wrap_ready cyc=%0d got=%b want=%b", cyc, req_ready, exp_ready()); end
    end
    req_valid = 4'b0;
    drain(ok);
    checks++; if (!ok || l_src.size() != 3) begin failures++; $display("FAIL wrap_count got=%0d want=3", l_src.size()); end
    for (int k = 0; k < 3 && k < l_src.size(); k++) begin
      checks++; if (l_src[k] != want_src[k]) begin failures++; $display("FAIL wrap_order[%0d] got=%0d want=%0d", k, l_src[k], want_src[k]); end
    end
  endtask

  task automatic test_gap_zero();
    do_reset();
    d0 = $urandom;
    v0 = 4'b0010;
    #1;
    checks++; if (r0 !== 4'b0010) begin failures++; $display("FAIL gap0_ready got=%b want=0010", r0); end
    step();
    v0 = 4'b0001;
    checks++; if (s0 !== 1'b1 || ts0 !== 2'd1 || td0 !== d0[15:8]) begin failures++; $display("FAIL gap0_launch got=%0b/%0d/%0h want=1/1/%0h", s0, ts0, td0, d0[15:8]); end
    step();
    step();
    #1;
    checks++; if (r0 !== 4'b0 || b0 !== 1'b1) begin failures++; $display("FAIL gap0_wait got=%b/%0b want=0000/1", r0, b0); end
    done0 = 1'b1;
    step();
    done0 = 1'b0;
    #1;
    checks++; if (r0 !== 4'b0001 || b0 !== 1'b0) begin failures++; $display("FAIL gap0_after_done got=%b/%0b want=0001/0", r0, b0); end
    step();
    v0 = 4'b0;
    checks++; if (s0 !== 1'b1 || ts0 !== 2'd0 || td0 !== d0[7:0]) begin failures++; $display("FAIL gap0_second got=%0b/%0d/%0h want=1/0/%0h", s0, ts0, td0, d0[7:0]); end
    step();
    done0 = 1'b1;
    step();
    done0 = 1'b0;
    checks++; if (b0 !== 1'b0) begin failures++; $display("FAIL gap0_idle got=%0b want=0", b0); end
  endtask

  task automatic test_random();
    int served;
    logic [7:0] b;
    bit ok;
    do_reset();
    auto_tx = 1'b1;
    baud_div = $urandom_range(2, 7);
    req_data = $urandom;
    served = 0;
    for (int g = 0; g < 30000 && served < 12; g++) begin
      tx_lat = $urandom_range(3, 60);
      step();
      if (tx_start) served++;
      if (m_hs) req_valid[2'(m_src)] = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (!req_valid[2'(i)] && $urandom_range(0, 7) == 0) begin
          b = 8'($urandom);
          req_data = (req_data & ~(32'hFF << (8 * i))) | (32'(b) << (8 * i));
          req_valid[2'(i)] = 1'b1;
        end else if (req_valid[2'(i)] && $urandom_range(0, 63) == 0) begin
          req_valid[2'(i)] = 1'b0;
        end
      end
      #1;
      checks++; if (req_ready !== exp_ready()) begin failures++; $display("FAIL rand_ready cyc=%0d got=%b want=%b", cyc, req_ready, exp_ready()); end
      checks++; if (busy !== !m_free) begin failures++; $display("FAIL rand_busy cyc=%0d got=%0b want=%0b", cyc, busy, !m_free); end
      checks++; if (tx_start !== m_start_due) begin failures++; $display("FAIL rand_start cyc=%0d got=%0b want=%0b", cyc, tx_start, m_start_due); end
      if (m_start_due) begin
        checks++; if (tx_data !== m_data || tx_src !== 2'(m_src)) begin failures++; $display("FAIL rand_frame cyc=%0d got=%0h/%0d want=%0h/%0d", cyc, tx_data, tx_src, m_data, m_src); end
      end
    end
    checks++; if (served < 12) begin failures++; $display("FAIL rand_progress got=%0d want=12", served); end
    req_valid = 4'b0;
    drain(ok);
    checks++; if (!ok) begin failures++; $display("FAIL rand_drain got=timeout want=idle"); end
    baud_div = 10;
  endtask

  initial begin
    rst = 1'b1; baud = 1'b0; tx_done = 1'b0; req_valid = 4'b0; req_data = 32'b0;
    v0 = 4'b0; d0 = 32'b0; done0 = 1'b0;
    auto_tx = 1'b0; tx_lat = 160; done_cnt = 0; force_done = 1'b0; baud_div = 10;
    n_start = 0; n_done = 0; last_done_idx = 0;
    m_free = 1'b1; m_start_due = 1'b0; m_in_flight = 1'b0; m_gap_left = 0;
    m_last = 3; m_src = 0; m_data = 8'h00; m_hs = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_spurious();
    test_reset_mid();
    test_wrap();
    test_gap_zero();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
